ecc_hostif: RTL
===============

# ecc_hostif

Host-side front end for `ecc_core`: it packs a narrow write stream into the core's 3*WIDTH operand bus, issues a single-cycle start with the selected mode, and watches the core's 2-bit status. On completion it captures the WIDTH-bit result and unloads it to the host as a word stream. It sits directly upstream of `ecc_core` and owns all operand/result buffering, command sequencing, error reporting and timeout detection.

## Interface
- `WIDTH`, 256: core operand/result width; must be a multiple of `BUSW`.
- `BUSW`, 32: host word width.
- `TOUTW`, 24: width of the timeout counter; timeout fires at 2^TOUTW−1 cycles in WAIT.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  1  host write strobe.
- `wr_data`  in  BUSW  operand word.
- `cmd_mode`  in  3  operation mode forwarded to core (MSB = EC op).
- `cmd_go`  in  1  start request.
- `rd_en`  in  1  host read-advance strobe.
- `rd_data`  out  BUSW  current result word.
- `rd_vld`  out  1  `rd_data` valid (state READ).
- `busy`  out  1  high in WAIT.
- `err`  out  1  sticky error flag.
- `core_din`  out  3*WIDTH  operand register to core.
- `core_mode`  out  3  registered mode.
- `core_start`  out  1  one-cycle start pulse.
- `core_dout`  in  WIDTH  core result.
- `core_status`  in  2  core status: 00 idle, 01 computing, 10 done, 11 error.

## Operation
- NW = 3*WIDTH/BUSW (24 by default); NR = WIDTH/BUSW (8 by default).
- States: IDLE, WAIT, READ. `wr_cnt` counts 0..NW; `rd_cnt` counts 0..NR−1.
- IDLE, `wr_en`:
  - If `wr_cnt`<NW: store `wr_data` in `core_din[wr_cnt*BUSW +: BUSW]` and increment `wr_cnt`. Word 0 is the LSB slice.
  - If `wr_cnt`==NW: ignore the write and set `err`.
- IDLE, `cmd_go`:
  - Evaluated against the post-write count, so the NW-th write and `cmd_go` in the same cycle is accepted.
  - If that count equals NW: register `cmd_mode` into `core_mode`, pulse `core_start`, clear `err` and the timeout counter, set `armed`=0, go to WAIT.
  - Otherwise: set `err` and stay in IDLE. `wr_cnt` is unchanged.
- WAIT:
  - `core_status`==01 sets `armed`.
  - Status 10 or 11 is honoured only when `armed`=1. This masks a stale "done" left over from the previous operation.
  - `armed` & 10: capture `core_dout` into the result register, set `rd_cnt`=0, go to READ.
  - `armed` & 11: set `err`, set `wr_cnt`=0, go to IDLE.
  - Timeout counter reaches all-ones: set `err`, set `wr_cnt`=0, go to IDLE.
- READ:
  - `rd_data` = result[`rd_cnt`*BUSW +: BUSW], driven combinationally from the registered result.
  - `rd_en` increments `rd_cnt`. `rd_en` while `rd_cnt`==NR−1 sets `wr_cnt`=0 and goes to IDLE.
- `wr_en` and `cmd_go` outside IDLE are ignored without error. `rd_en` outside READ is ignored.
- `core_din` keeps its contents across operations. Only `wr_cnt` rewinds, so a new load overwrites it.
- `err` remains set until the next accepted `cmd_go`, or reset.

## Timing
- Reset values: state IDLE; `wr_cnt`, `rd_cnt`, `armed` = 0; timeout counter = 0; result register = 0.
- Output reset values: `core_din`=0, `core_mode`=0, `core_start`=0, `err`=0, `busy`=0, `rd_vld`=0, `rd_data`=0.
- Reset asserted mid-operation aborts immediately to these values. No pulse is emitted on reset release.
- `cmd_go` accepted at cycle t: `core_start`=1 and `busy`=1 at t+1. `core_start` is exactly one cycle wide. `core_mode` and `core_din` are stable from t+1 through the end of WAIT.
- Armed status 10 sampled at cycle t: `rd_vld`=1 with word 0 on `rd_data` at t+1, and `busy`=0.
- `rd_en` at cycle t: the next word appears at t+1. After the last `rd_en`, `rd_vld`=0 at t+1.
- `err` is registered and rises one cycle after the causing event.
- Throughput: one write or one read per cycle. No backpressure toward the host.

## Test plan
- Load 24 words 0x00000001..0x00000018, then `cmd_go` with mode=3'b100 → `core_din`[31:0]=1 and `core_din`[767:736]=0x18; `core_start` high for 1 cycle with `core_mode`=4; model core returns status 01 then 10 with `core_dout`=0x…0807060504030201 → 8 reads yield 0x04030201, 0x08070605, …, then `rd_vld`=0.
- `cmd_go` after only 23 words → `err`=1, no `core_start`. A 24th write followed by `cmd_go` → accepted and `err` clears.
- Core holds status 10 from the prior op for 3 cycles after start, then 01, then 10 → capture happens only on the second 10.
- Core reports 01 then 11 → `err`=1, back to IDLE, `wr_cnt`=0; `rd_vld` never asserts.
- `TOUTW`=4 with core stuck at 00 → `err`=1 and IDLE after 15 WAIT cycles. Also: a 25th write in IDLE → `err`=1; `wr_en`/`cmd_go` during WAIT/READ → no effect.
- Assert `rst` during WAIT and again during READ → all outputs return to reset values asynchronously. A fresh 24-word load and op then completes correctly.

Source files
------------

// File: rtl/ecc_hostif.sv
// ecc_hostif: host-side front end for ecc_core.
//   Packs a BUSW-wide host write stream into the 3*WIDTH operand bus and issues a single-cycle
//   start with the registered mode. It then watches the core status, with a timeout, and unloads
//   the WIDTH-bit result to the host one BUSW word per rd_en.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wr_en, wr_data             host operand write stream (word 0 = LSB slice)
//   cmd_mode, cmd_go           operation mode and start request
//   rd_en, rd_data, rd_vld     host result read stream
//   busy, err                  waiting on core / sticky error
//   core_din, core_mode        operand register and registered mode to core
//   core_start                 one-cycle start pulse
//   core_dout, core_status     core result and status (00 idle, 01 run, 10 done, 11 error)
module ecc_hostif #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned BUSW  = 32,
  parameter int unsigned TOUTW = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [BUSW-1:0]    wr_data,
  input  logic [2:0]         cmd_mode,
  input  logic               cmd_go,
  input  logic               rd_en,
  output logic [BUSW-1:0]    rd_data,
  output logic               rd_vld,
  output logic               busy,
  output logic               err,
  output logic [3*WIDTH-1:0] core_din,
  output logic [2:0]         core_mode,
  output logic               core_start,
  input  logic [WIDTH-1:0]   core_dout,
  input  logic [1:0]         core_status
);

  localparam int unsigned NW    = 3 * WIDTH / BUSW;
  localparam int unsigned NR    = WIDTH / BUSW;
  localparam int unsigned WcW   = $clog2(NW + 1);
  localparam int unsigned RcW   = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned DinIw = $clog2(3 * WIDTH);
  localparam int unsigned ResIw = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WcW-1:0]   WrFull = WcW'(NW);
  localparam logic [RcW-1:0]   RdLast = RcW'(NR - 1);
  // Counter is one short of all-ones: the increment that reaches all-ones is the timeout,
  // giving exactly 2^TOUTW-1 cycles in WAIT.
  localparam logic [TOUTW-1:0] ToutFire = ~TOUTW'(1);

  localparam logic [1:0] StatRun  = 2'b01;
  localparam logic [1:0] StatDone = 2'b10;
  localparam logic [1:0] StatErr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StRead} state_e;

  state_e               state_q, state_d;
  logic [WcW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [RcW-1:0]       rd_cnt_q, rd_cnt_d;
  logic                 armed_q, armed_d;
  logic [TOUTW-1:0]     tout_q, tout_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [3*WIDTH-1:0]   din_q, din_d;
  logic [2:0]           mode_q, mode_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;

  logic [WcW-1:0]       wr_cnt_post;
  logic [DinIw-1:0]     wr_idx;
  logic [ResIw-1:0]     rd_idx;

  assign wr_idx = DinIw'(wr_cnt_q) * DinIw'(BUSW);
  assign rd_idx = ResIw'(rd_cnt_q) * ResIw'(BUSW);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      armed_q  <= 1'b0;
      tout_q   <= '0;
      res_q    <= '0;
      din_q    <= '0;
      mode_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      armed_q  <= armed_d;
      tout_q   <= tout_d;
      res_q    <= res_d;
      din_q    <= din_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    armed_d     = armed_q;
    tout_d      = tout_q;
    res_d       = res_q;
    din_d       = din_q;
    mode_d      = mode_q;
    start_d     = 1'b0;
    err_d       = err_q;
    wr_cnt_post = wr_cnt_q;

    case (state_q)
      StIdle: begin
        if (wr_en) begin
          if (wr_cnt_q < WrFull) begin
            din_d[wr_idx +: BUSW] = wr_data;
            wr_cnt_post           = wr_cnt_q + WcW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        wr_cnt_d = wr_cnt_post;
        // cmd_go sees the post-write count so the last write and go may share a cycle.
        if (cmd_go) begin
          if (wr_cnt_post == WrFull) begin
            mode_d  = cmd_mode;
            start_d = 1'b1;
            err_d   = 1'b0;
            tout_d  = '0;
            armed_d = 1'b0;
            state_d = StWait;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StWait: begin
        tout_d = tout_q + TOUTW'(1);
        if (core_status == StatRun) armed_d = 1'b1;
        // Done/error only count once the core has shown it is running this op;
        // a stale done from the previous op is ignored.
        if (armed_q && core_status == StatDone) begin
          res_d    = core_dout;
          rd_cnt_d = '0;
          state_d  = StRead;
        end else if ((armed_q && core_status == StatErr) || tout_q == ToutFire) begin
          err_d    = 1'b1;
          wr_cnt_d = '0;
          state_d  = StIdle;
        end
      end

      StRead: begin
        if (rd_en) begin
          if (rd_cnt_q == RdLast) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            state_d  = StIdle;
          end else begin
            rd_cnt_d = rd_cnt_q + RcW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy       = 1'b0;
    rd_vld     = 1'b0;
    case (state_q)
      StWait:  busy   = 1'b1;
      StRead:  rd_vld = 1'b1;
      default: ;
    endcase
    rd_data    = res_q[rd_idx +: BUSW];
    err        = err_q;
    core_din   = din_q;
    core_mode  = mode_q;
    core_start = start_q;
  end

endmodule
